// File: rtl/seq_arith_unit_if.sv
// Command/result bundle between the command issuer and seq_arith_unit.
//
// Handshake: a command is taken on a rising clk edge where i_valid=1 and
// o_ready=1; operands and opcode must be stable at that edge. o_valid is a
// one-cycle pulse marking the cycle in which o_result/o_status were updated;
// there is no result back-pressure, and results hold until the next pulse.
//
// Signals:
//   i_valid, iarg_A, iarg_B, iop  : command from issuer
//   o_ready                       : unit can accept a command
//   o_valid, o_result, o_status   : result to register file
//   dbg_state                     : FSM state (0=IDLE, 1=DIV), observation only
interface seq_arith_unit_if #(
  parameter int M = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [M-1:0] iarg_A;
  logic [M-1:0] iarg_B;
  logic [3:0]   iop;
  logic         o_valid;
  logic [M-1:0] o_result;
  logic [3:0]   o_status;
  logic         dbg_state;

  modport master (
    output i_valid, iarg_A, iarg_B, iop,
    input  o_ready, o_valid, o_result, o_status, dbg_state
  );

  modport slave (
    input  i_valid, iarg_A, iarg_B, iop,
    output o_ready, o_valid, o_result, o_status, dbg_state
  );
endinterface

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: handshaked arithmetic unit, one operation in flight.
// Single-cycle ops (shift, compare, sign conversions, divide-by-zero and
// illegal opcodes) produce a result the cycle after acceptance. Divide and
// remainder with a nonzero divisor run an M-step restoring divider.
//
// Ports:
//   clk      : rising-edge clock
//   i_reset  : synchronous active-high reset
//   bus      : seq_arith_unit_if.slave (command in, result/status out)
//
// Status: [3]=ERROR [2]=NOT_EVEN_1 (XOR of result) [1]=ZEROS [0]=OVERFLOW.
// The operand B is always used inverted (Bn = ~iarg_B).
module seq_arith_unit #(
  parameter int M = 32
) (
  input  logic            clk,
  input  logic            i_reset,
  seq_arith_unit_if.slave bus
);
  localparam int SHW = $clog2(M);
  localparam int CW  = SHW + 1;
  localparam logic [M-1:0] M_LIM = M'(M);
  localparam logic [M-1:0] MIN_NEG = {1'b1, {(M-1){1'b0}}};

  localparam logic [3:0] OP_SHR  = 4'b0000;
  localparam logic [3:0] OP_LE   = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b0010;
  localparam logic [3:0] OP_SM2U = 4'b0011;
  localparam logic [3:0] OP_U2SM = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0101;

  typedef enum logic {IDLE = 1'b0, DIV = 1'b1} state_t;

  state_t        state;
  logic          ready_q;
  logic          valid_q;
  logic [M-1:0]  result_q;
  logic [3:0]    status_q;

  logic [M-1:0]  dvd;
  logic [M-1:0]  dvs;
  logic [M-1:0]  rem;
  logic [M-1:0]  quo;
  logic [CW-1:0] cnt;
  logic          op_is_rem;

  logic [M-1:0]  bn;
  logic [M-1:0]  sc_res;
  logic          sc_err;
  logic          sc_ovf;
  logic          start_div;

  assign bn = ~bus.iarg_B;

  function automatic logic [3:0] mk_status(input logic [M-1:0] r,
                                           input logic err,
                                           input logic ovf);
    return {err, ^r, (r == '0), ovf};
  endfunction

  // Single-cycle datapath, evaluated on the live command inputs.
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    sc_ovf = 1'b0;
    case (bus.iop)
      OP_SHR: begin
        if (bn >= M_LIM) sc_err = 1'b1;
        else             sc_res = bus.iarg_A >> bn[SHW-1:0];
      end
      OP_LE: sc_res = {{(M-1){1'b0}}, (bus.iarg_A <= bn)};
      OP_DIV, OP_REM: begin
        // Only reached here for a zero divisor; nonzero goes to DIV.
        sc_err = 1'b1;
      end
      OP_SM2U: begin
        // Negating the magnitude also maps negative zero onto 0.
        if (bus.iarg_A[M-1]) sc_res = '0 - {1'b0, bus.iarg_A[M-2:0]};
        else                 sc_res = {1'b0, bus.iarg_A[M-2:0]};
      end
      OP_U2SM: begin
        if (bus.iarg_A == MIN_NEG) begin
          sc_res = bus.iarg_A;
          sc_ovf = 1'b1;
        end else if (bus.iarg_A[M-1]) begin
          sc_res = {1'b1, sc_neg_low(bus.iarg_A)};
        end else begin
          sc_res = bus.iarg_A;
        end
      end
      default: sc_err = 1'b1;
    endcase
  end

  function automatic logic [M-2:0] sc_neg_low(input logic [M-1:0] a);
    logic [M-1:0] n;
    n = '0 - a;
    return n[M-2:0];
  endfunction

  assign start_div = ((bus.iop == OP_DIV) || (bus.iop == OP_REM)) && (bn != '0);

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  logic [M:0]   step_t;
  logic [M:0]   step_diff;
  logic         step_ge;
  logic [M-1:0] rem_n;
  logic [M-1:0] quo_n;

  always_comb begin
    step_t    = {rem, dvd[M-1]};
    step_diff = step_t - {1'b0, dvs};
    step_ge   = (step_t >= {1'b0, dvs});
    rem_n     = step_ge ? step_diff[M-1:0] : step_t[M-1:0];
    quo_n     = {quo[M-2:0], step_ge};
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      result_q  <= '0;
      status_q  <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      op_is_rem <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_valid && ready_q) begin
            if (start_div) begin
              dvd       <= bus.iarg_A;
              dvs       <= bn;
              rem       <= '0;
              quo       <= '0;
              cnt       <= CW'(M);
              op_is_rem <= (bus.iop == OP_REM);
              ready_q   <= 1'b0;
              state     <= DIV;
            end else begin
              result_q <= sc_res;
              status_q <= mk_status(sc_res, sc_err, sc_ovf);
              valid_q  <= 1'b1;
            end
          end
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - CW'(1);
          // Final step: publish the freshly computed step output directly.
          if (cnt == CW'(1)) begin
            result_q <= op_is_rem ? rem_n : quo_n;
            status_q <= mk_status(op_is_rem ? rem_n : quo_n, 1'b0, 1'b0);
            valid_q  <= 1'b1;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_result  = result_q;
  assign bus.o_status  = status_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Testbench for seq_arith_unit (M=8): directed vectors with hand-computed
// expected results; a scoreboard queue is filled at issue and drained by a
// monitor on every o_valid pulse.
module tb_seq_arith_unit;
  localparam int M = 8;

  logic clk;
  logic i_reset;
  int   total;
  int   bad;
  int   valid_cnt;
  int   n_expected;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;

  seq_arith_unit_if #(.M(M)) bus ();

  seq_arith_unit #(.M(M)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // driver: present one command for one edge, push expected response
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] es);
    bus.i_valid = 1'b1;
    bus.iop     = op;
    bus.iarg_A  = a;
    bus.iarg_B  = b;
    check("ready_at_issue", {31'b0, bus.o_ready}, 32'd1);
    exp_q.push_back({er, es});
    n_expected++;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  // divide with a nonzero divisor; i_valid stays high while busy
  task automatic div_run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [3:0] es);
    send(op, a, b, er, es);
    bus.i_valid = 1'b1;
    bus.iop     = 4'b0001;
    bus.iarg_A  = 8'h00;
    bus.iarg_B  = 8'h00;
    for (int k = 0; k < M; k++) begin
      check("div_busy_ready", {31'b0, bus.o_ready}, 32'd0);
      check("div_busy_valid", {31'b0, bus.o_valid}, 32'd0);
      check("div_busy_state", {31'b0, bus.dbg_state}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    check("div_done_valid", {31'b0, bus.o_valid}, 32'd1);
    check("div_done_ready", {31'b0, bus.o_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("div_valid_once", {31'b0, bus.o_valid}, 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!i_reset && bus.o_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid result=%0h status=%0h t=%0t",
                 bus.o_result, bus.o_status, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {24'b0, bus.o_result}, {24'b0, mon_e[11:4]});
        check("status", {28'b0, bus.o_status}, {28'b0, mon_e[3:0]});
      end
    end
  end

  initial begin
    total = 0; bad = 0; valid_cnt = 0; n_expected = 0;
    bus.i_valid = 1'b0;
    bus.iop     = 4'h0;
    bus.iarg_A  = '0;
    bus.iarg_B  = '0;
    i_reset     = 1'b1;
    bus.i_valid = 1'b1;   // must be ignored during reset
    repeat (2) @(posedge clk);
    #1;
    i_reset     = 1'b0;
    bus.i_valid = 1'b0;
    check("rst_result", {24'b0, bus.o_result}, 32'd0);
    check("rst_status", {28'b0, bus.o_status}, 32'd0);
    check("rst_valid",  {31'b0, bus.o_valid}, 32'd0);
    check("rst_ready",  {31'b0, bus.o_ready}, 32'd1);
    check("rst_state",  {31'b0, bus.dbg_state}, 32'd0);

    // shifts
    send(4'b0000, 8'hF0, 8'hFC, 8'h1E, 4'b0000);
    send(4'b0000, 8'hF0, 8'hF0, 8'h00, 4'b1010);
    send(4'b0000, 8'h80, 8'hF8, 8'h01, 4'b0100);   // Bn=7, largest legal
    send(4'b0000, 8'h80, 8'hF7, 8'h00, 4'b1010);   // Bn=8, out of range
    @(posedge clk); #1;

    // multi-cycle divide / remainder
    div_run(4'b0010, 8'h64, 8'hF5, 8'h0A, 4'b0000);
    div_run(4'b0101, 8'h65, 8'hF5, 8'h01, 4'b0100);
    div_run(4'b0010, 8'hFF, 8'hFE, 8'hFF, 4'b0000); // /1

    // divide by zero is single-cycle
    send(4'b0010, 8'h37, 8'hFF, 8'h00, 4'b1010);
    check("div0_valid", {31'b0, bus.o_valid}, 32'd1);
    check("div0_ready", {31'b0, bus.o_ready}, 32'd1);
    send(4'b0101, 8'h37, 8'hFF, 8'h00, 4'b1010);
    check("rem0_ready", {31'b0, bus.o_ready}, 32'd1);

    // sign conversions and compare
    send(4'b0011, 8'h85, 8'h00, 8'hFB, 4'b0100);
    send(4'b0011, 8'h80, 8'h00, 8'h00, 4'b0010);   // negative zero
    send(4'b0100, 8'h80, 8'h00, 8'h80, 4'b0101);
    send(4'b0100, 8'hFB, 8'h00, 8'h85, 4'b0100);
    send(4'b0001, 8'h03, 8'hFC, 8'h01, 4'b0100);
    @(posedge clk); #1;

    // back-to-back
    send(4'b0000, 8'hF0, 8'hFC, 8'h1E, 4'b0000);
    send(4'b0001, 8'h03, 8'hFC, 8'h01, 4'b0100);
    send(4'b1111, 8'h12, 8'h34, 8'h00, 4'b1010);
    @(posedge clk); #1;

    // reset during a divide
    send(4'b0010, 8'h64, 8'hF5, 8'h0A, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    void'(exp_q.pop_back());
    n_expected--;
    check("abort_result", {24'b0, bus.o_result}, 32'd0);
    check("abort_status", {28'b0, bus.o_status}, 32'd0);
    check("abort_valid",  {31'b0, bus.o_valid}, 32'd0);
    check("abort_ready",  {31'b0, bus.o_ready}, 32'd1);
    send(4'b0001, 8'h05, 8'hFC, 8'h00, 4'b0010);

    // drain: catch stray pulses from the aborted divide
    repeat (2 * M + 4) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    check("valid_count", valid_cnt, n_expected);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
- Parametrised, handshaked successor of the single-cycle synchronous ALU.
- Keeps the existing opcode and status-flag map (shift, compare, divide, sign-magnitude to U2) and adds remainder and U2 to sign-magnitude.
- Division becomes a multi-cycle restoring divider with valid/ready flow control.
- Sits between the command issuer and the result register file; one operation is in flight at a time.

Parameters:
M, 32, operand/result width in bits (M >= 4). SHW = $clog2(M) is derived internally.

Ports:
clk  in  1  clock, rising edge
i_reset  in  1  synchronous reset, active-high
i_valid  in  1  command valid
o_ready  out  1  unit can accept a command
iarg_A  in  M  operand A
iarg_B  in  M  operand B (every op uses ~iarg_B)
iop  in  4  opcode
o_valid  out  1  one-cycle pulse: o_result/o_status updated
o_result  out  M  result, held until next o_valid
o_status  out  4  flags [3]=ERROR [2]=NOT_EVEN_1 [1]=ZEROS [0]=OVERFLOW, held until next o_valid

Behaviour:
- Reset: one clock, synchronous, active-high; reset is decided as such.
  - Reset values: o_result=0, o_status=0, o_valid=0, o_ready=1, FSM=IDLE.
  - Reset overrides everything, including an in-flight divide (aborted, no o_valid).
  - i_valid is ignored while i_reset=1.
- Accept: a command is taken at a rising edge with i_valid=1 and o_ready=1. Operands and opcode are latched at that edge (edge E).
- FSM has two states, IDLE and DIV.
- IDLE, non-divide op, or divide with divisor zero:
  - The result is computed and registered at E; o_valid=1 for the cycle after E.
  - o_ready stays 1, so back-to-back accepts give 1 result per cycle.
- IDLE, op 0010/0101 with ~iarg_B != 0:
  - Latch dividend and divisor, clear the partial remainder and quotient, set counter=M.
  - Go to DIV; o_ready=0 from E.
- DIV:
  - Each edge does one restoring step, MSB first, and decrements the counter.
  - On the edge where the counter reaches 0 (E+M): write the quotient (0010) or remainder (0101) to o_result, set o_valid=1 and o_ready=1, and return to IDLE.
  - A new command is accepted no earlier than edge E+M+1.
- o_valid is 0 in every cycle with no result written; it never asserts two cycles per divide.
- Opcodes (unsigned unless stated; Bn = ~iarg_B):
  - 0000: A >> Bn. If Bn >= M, result 0 and ERROR=1.
  - 0001: result 1 if A <= Bn, else 0.
  - 0010: A / Bn. If Bn==0, result 0 and ERROR=1, single-cycle.
  - 0011: sign-magnitude to U2 on A.
    - Sign=0: result {0, A[M-2:0]}.
    - Sign=1: result -(A[M-2:0]) in M bits; negative zero gives 0.
  - 0100: U2 to sign-magnitude on A.
    - A >= 0: result unchanged.
    - A < 0: result {1, |A|[M-2:0]}.
    - A == 100..0 cannot be represented: result = A, OVERFLOW=1.
  - 0101: A % Bn. If Bn==0, result 0 and ERROR=1.
  - Others: result 0, ERROR=1.
- Flags:
  - All four flags are rewritten on every o_valid; unset flags are 0.
  - ZEROS = (o_result == 0).
  - NOT_EVEN_1 = XOR-reduce of o_result.
  - Both are derived from the value written, including error results.
- No X is ever driven on o_result.

Test Plan:
- M=8, op 0000, A=0xF0, B=0xFC (Bn=3), i_valid one cycle -> next cycle o_valid=1, o_result=0x1E, o_status=0000. Then B=0xF0 (Bn=15) -> o_result=0x00, o_status=1010.
- M=8, op 0010, A=0x64, B=0xF5 (Bn=10) -> o_ready=0 for 8 cycles, o_valid exactly once at E+8, o_result=0x0A, o_status=0000. i_valid held high during DIV is not accepted. Repeat with op 0101, A=0x65 -> o_result=0x01, o_status=0100.
- M=8, op 0010, B=0xFF (Bn=0) -> single-cycle o_valid, o_result=0x00, o_status=1010, o_ready never drops.
- M=8, op 0011, A=0x85 -> o_result=0xFB, o_status=0100. Op 0100, A=0x80 -> o_result=0x80, o_status=0101. Op 0001, A=0x03, B=0xFC -> o_result=0x01.
- Back-to-back: ops 0000, 0001, 1111 on consecutive cycles -> three consecutive o_valid pulses; the third gives o_result=0, o_status=1010.
- Divide in flight, i_reset=1 at E+4 for 1 cycle -> no o_valid, o_result=0, o_status=0, o_ready=1 after reset. A new op 0001 is accepted immediately after.
